// File: rtl/mc_control_if.sv
// mc_control_if
//   Bundles the multicycle controller's datapath-facing signals.
//   master : datapath side (drives opcode and mem_ready, observes controls)
//   slave  : controller side (mc_control)
//   Signals:
//     opcode[5:0], mem_ready                 -> controller
//     read_mem, write_mem, ir_write, pc_write,
//     pc_write_cond, branch_ne, mux_pc_src[1:0],
//     write_reg, mux_write_rt_rd, mux_alu_src_reg_imm,
//     mux_reg_src_alu_mem, alu_op[ALUOP_W-1:0],
//     state[2:0], fault, instr_count[CNT_W-1:0] <- controller
interface mc_control_if #(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) ();
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               read_mem;
    logic               write_mem;
    logic               ir_write;
    logic               pc_write;
    logic               pc_write_cond;
    logic               branch_ne;
    logic [1:0]         mux_pc_src;
    logic               write_reg;
    logic               mux_write_rt_rd;
    logic               mux_alu_src_reg_imm;
    logic               mux_reg_src_alu_mem;
    logic [ALUOP_W-1:0] alu_op;
    logic [2:0]         state;
    logic               fault;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        output opcode, mem_ready,
        input  read_mem, write_mem, ir_write, pc_write, pc_write_cond,
               branch_ne, mux_pc_src, write_reg, mux_write_rt_rd,
               mux_alu_src_reg_imm, mux_reg_src_alu_mem, alu_op,
               state, fault, instr_count
    );

    modport slave (
        input  opcode, mem_ready,
        output read_mem, write_mem, ir_write, pc_write, pc_write_cond,
               branch_ne, mux_pc_src, write_reg, mux_write_rt_rd,
               mux_alu_src_reg_imm, mux_reg_src_alu_mem, alu_op,
               state, fault, instr_count
    );
endinterface

// File: rtl/mc_control.sv
// mc_control
//   Multicycle MIPS-subset control unit: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//   Memory accesses in FETCH and MEM are guarded by a wait counter; running
//   out of patience, or decoding an unsupported opcode, parks the FSM in
//   FAULT until reset. instr_count counts retired instructions.
//   Ports:
//     clk   : rising-edge clock
//     nrst  : synchronous active-low reset; also forces outputs idle
//             combinationally while low
//     bus   : mc_control_if.slave (opcode/mem_ready in, controls out)
module mc_control #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         nrst,
    mc_control_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'b000,
        ST_DECODE = 3'b001,
        ST_EXEC   = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB     = 3'b100,
        ST_FAULT  = 3'b111
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_BEQ  = 4'b0001;
    localparam logic [3:0] ALU_FUNC = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_BNE  = 4'b0100;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_R, OP_ADDI, OP_ADDIU, OP_ANDI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_J: op_supported = 1'b1;
            default:              op_supported = 1'b0;
        endcase
    endfunction

    state_t           state_q, state_nxt;
    logic [5:0]       op_q;
    logic [7:0]       wait_q, wait_nxt, wait_inc;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    logic       read_mem, write_mem, ir_write, pc_write, pc_write_cond, branch_ne;
    logic [1:0] mux_pc_src;
    logic       write_reg, mux_write_rt_rd, mux_alu_src_reg_imm, mux_reg_src_alu_mem;
    logic [3:0] alu_op_c;

    assign wait_inc = wait_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_FETCH;
            op_q    <= 6'b000000;
            wait_q  <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            wait_q  <= wait_nxt;
            // The opcode is captured once; later stages never look at the input.
            if (state_q == ST_DECODE) begin
                op_q <= bus.opcode;
            end
            if (retire) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt           = state_q;
        // Counter is zero on every entry to FETCH/MEM because only the
        // waiting branches below keep a non-zero value.
        wait_nxt            = 8'd0;
        read_mem            = 1'b0;
        write_mem           = 1'b0;
        ir_write            = 1'b0;
        pc_write            = 1'b0;
        pc_write_cond       = 1'b0;
        branch_ne           = 1'b0;
        mux_pc_src          = 2'b00;
        write_reg           = 1'b0;
        mux_write_rt_rd     = 1'b0;
        mux_alu_src_reg_imm = 1'b0;
        mux_reg_src_alu_mem = 1'b0;
        alu_op_c            = ALU_ADD;

        if (!nrst) begin
            alu_op_c  = ALU_FUNC;
            state_nxt = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    read_mem = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        state_nxt = ST_DECODE;
                    end else if (wait_inc == TIMEOUT_C) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        wait_nxt = wait_inc;
                    end
                end
                ST_DECODE: begin
                    state_nxt = op_supported(bus.opcode) ? ST_EXEC : ST_FAULT;
                end
                ST_EXEC: begin
                    case (op_q)
                        OP_R: begin
                            alu_op_c  = ALU_FUNC;
                            state_nxt = ST_WB;
                        end
                        OP_ADDI, OP_ADDIU: begin
                            alu_op_c            = ALU_ADD;
                            mux_alu_src_reg_imm = 1'b1;
                            state_nxt           = ST_WB;
                        end
                        OP_ANDI: begin
                            alu_op_c            = ALU_AND;
                            mux_alu_src_reg_imm = 1'b1;
                            state_nxt           = ST_WB;
                        end
                        OP_LW, OP_SW: begin
                            alu_op_c            = ALU_ADD;
                            mux_alu_src_reg_imm = 1'b1;
                            state_nxt           = ST_MEM;
                        end
                        OP_BEQ: begin
                            pc_write_cond = 1'b1;
                            mux_pc_src    = 2'b01;
                            alu_op_c      = ALU_BEQ;
                            state_nxt     = ST_FETCH;
                        end
                        OP_BNE: begin
                            pc_write_cond = 1'b1;
                            branch_ne     = 1'b1;
                            mux_pc_src    = 2'b01;
                            alu_op_c      = ALU_BNE;
                            state_nxt     = ST_FETCH;
                        end
                        OP_J: begin
                            pc_write   = 1'b1;
                            mux_pc_src = 2'b10;
                            state_nxt  = ST_FETCH;
                        end
                        default: state_nxt = ST_FAULT;
                    endcase
                end
                ST_MEM: begin
                    // Only LW and SW can reach MEM, so anything not LW is a store.
                    if (op_q == OP_LW) begin
                        read_mem = 1'b1;
                    end else begin
                        write_mem = 1'b1;
                    end
                    if (bus.mem_ready) begin
                        state_nxt = (op_q == OP_LW) ? ST_WB : ST_FETCH;
                    end else if (wait_inc == TIMEOUT_C) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        wait_nxt = wait_inc;
                    end
                end
                ST_WB: begin
                    write_reg           = 1'b1;
                    mux_write_rt_rd     = (op_q == OP_R);
                    mux_reg_src_alu_mem = (op_q != OP_LW);
                    state_nxt           = ST_FETCH;
                end
                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end
                default: begin
                    state_nxt = ST_FAULT;
                end
            endcase
        end
    end

    // An instruction retires when the FSM heads back to FETCH from a
    // post-decode state; reset is excluded since state_nxt is forced there.
    assign retire = nrst && (state_nxt == ST_FETCH) &&
                    ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB));

    assign bus.read_mem            = read_mem;
    assign bus.write_mem           = write_mem;
    assign bus.ir_write            = ir_write;
    assign bus.pc_write            = pc_write;
    assign bus.pc_write_cond       = pc_write_cond;
    assign bus.branch_ne           = branch_ne;
    assign bus.mux_pc_src          = mux_pc_src;
    assign bus.write_reg           = write_reg;
    assign bus.mux_write_rt_rd     = mux_write_rt_rd;
    assign bus.mux_alu_src_reg_imm = mux_alu_src_reg_imm;
    assign bus.mux_reg_src_alu_mem = mux_reg_src_alu_mem;
    assign bus.alu_op              = ALUOP_W'(alu_op_c);
    assign bus.state               = state_q;
    assign bus.fault               = (state_q == ST_FAULT);
    assign bus.instr_count         = cnt_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control
//   Drives two controllers (16-bit and 4-bit retire counters) with identical
//   stimulus. Each instruction is expanded into its expected cycle schedule
//   (fetch waits, decode, exec, memory waits, writeback) and every cycle's
//   state and control vector is compared to the schedule.
module tb_mc_control;

    localparam logic [2:0] S_FETCH  = 3'b000;
    localparam logic [2:0] S_DECODE = 3'b001;
    localparam logic [2:0] S_EXEC   = 3'b010;
    localparam logic [2:0] S_MEM    = 3'b011;
    localparam logic [2:0] S_WB     = 3'b100;
    localparam logic [2:0] S_FAULT  = 3'b111;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Control vector bit layout:
    // 11 read_mem, 10 write_mem, 9 ir_write, 8 pc_write, 7 pc_write_cond,
    // 6 branch_ne, 5:4 mux_pc_src, 3 write_reg, 2 mux_write_rt_rd,
    // 1 mux_alu_src_reg_imm, 0 mux_reg_src_alu_mem
    localparam logic [11:0] C_RD    = 12'h800;
    localparam logic [11:0] C_WR    = 12'h400;
    localparam logic [11:0] C_IRW   = 12'h200;
    localparam logic [11:0] C_PCW   = 12'h100;
    localparam logic [11:0] C_PCC   = 12'h080;
    localparam logic [11:0] C_BNE   = 12'h040;
    localparam logic [11:0] C_SRCB  = 12'h010;
    localparam logic [11:0] C_SRCJ  = 12'h020;
    localparam logic [11:0] C_WREG  = 12'h008;
    localparam logic [11:0] C_RTRD  = 12'h004;
    localparam logic [11:0] C_IMM   = 12'h002;
    localparam logic [11:0] C_ALU   = 12'h001;

    logic clk;
    logic nrst;
    int   total;
    int   bad;
    int   model_cnt;

    mc_control_if #(.ALUOP_W(4), .CNT_W(16)) ifa ();
    mc_control_if #(.ALUOP_W(4), .CNT_W(4))  ifb ();

    mc_control #(.ALUOP_W(4), .MEM_TIMEOUT(15), .CNT_W(16)) dut_a (
        .clk  (clk),
        .nrst (nrst),
        .bus  (ifa)
    );

    mc_control #(.ALUOP_W(4), .MEM_TIMEOUT(15), .CNT_W(4)) dut_b (
        .clk  (clk),
        .nrst (nrst),
        .bus  (ifb)
    );

    logic [11:0] ctl_a;
    logic [11:0] ctl_b;
    assign ctl_a = {ifa.read_mem, ifa.write_mem, ifa.ir_write, ifa.pc_write,
                    ifa.pc_write_cond, ifa.branch_ne, ifa.mux_pc_src, ifa.write_reg,
                    ifa.mux_write_rt_rd, ifa.mux_alu_src_reg_imm, ifa.mux_reg_src_alu_mem};
    assign ctl_b = {ifb.read_mem, ifb.write_mem, ifb.ir_write, ifb.pc_write,
                    ifb.pc_write_cond, ifb.branch_ne, ifb.mux_pc_src, ifb.write_reg,
                    ifb.mux_write_rt_rd, ifb.mux_alu_src_reg_imm, ifb.mux_reg_src_alu_mem};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic supported(input logic [5:0] op);
        return op inside {OP_R, OP_ADDI, OP_ADDIU, OP_ANDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
    endfunction

    function automatic logic [11:0] exec_ctl(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_LW, OP_SW: return C_IMM;
            OP_BEQ: return C_PCC | C_SRCB;
            OP_BNE: return C_PCC | C_SRCB | C_BNE;
            OP_J:   return C_PCW | C_SRCJ;
            default: return 12'h000;
        endcase
    endfunction

    // -1 means the ALU class is not specified for this instruction.
    function automatic int exec_alu(input logic [5:0] op);
        case (op)
            OP_R:    return 2;
            OP_ANDI: return 3;
            OP_BEQ:  return 1;
            OP_BNE:  return 4;
            OP_J:    return -1;
            default: return 0;
        endcase
    endfunction

    function automatic logic has_wb(input logic [5:0] op);
        return op inside {OP_R, OP_ADDI, OP_ADDIU, OP_ANDI, OP_LW};
    endfunction

    function automatic logic [11:0] wb_ctl(input logic [5:0] op);
        logic [11:0] c;
        c = C_WREG;
        if (op == OP_R)  c = c | C_RTRD;
        if (op != OP_LW) c = c | C_ALU;
        return c;
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    // Called just after a rising edge: apply inputs, compare mid-cycle, advance.
    task automatic cyc(input logic [5:0] op, input logic rdy, input logic [2:0] es,
                       input logic [11:0] ec, input int ea);
        ifa.opcode    = op;
        ifa.mem_ready = rdy;
        ifb.opcode    = op;
        ifb.mem_ready = rdy;
        @(negedge clk);
        check("state", 32'(ifa.state), 32'(es));
        check("ctl", 32'(ctl_a), 32'(ec));
        check("fault", 32'(ifa.fault), 32'(es == S_FAULT));
        check("state_b", 32'(ifb.state), 32'(es));
        check("ctl_b", 32'(ctl_b), 32'(ec));
        if (ea >= 0) begin
            check("alu_op", 32'(ifa.alu_op), 32'(ea));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        check(tag, 32'(ifa.instr_count), 32'(model_cnt & 'hFFFF));
        check({tag, "_b"}, 32'(ifb.instr_count), 32'(model_cnt & 'hF));
    endtask

    task automatic do_reset();
        nrst          = 1'b0;
        ifa.opcode    = rnd6();
        ifa.mem_ready = rnd1();
        ifb.opcode    = ifa.opcode;
        ifb.mem_ready = ifa.mem_ready;
        @(negedge clk);
        check("rst_ctl", 32'(ctl_a), 32'h0);
        check("rst_ctl_b", 32'(ctl_b), 32'h0);
        check("rst_alu", 32'(ifa.alu_op), 32'h2);
        @(posedge clk);
        #1;
        nrst      = 1'b1;
        model_cnt = 0;
        check("rst_state", 32'(ifa.state), 32'(S_FETCH));
        check("rst_fault", 32'(ifa.fault), 32'h0);
        check_cnt("rst_cnt");
    endtask

    task automatic hold_fault();
        for (int i = 0; i < 4; i++) begin
            cyc(rnd6(), rnd1(), S_FAULT, 12'h000, -1);
        end
        check_cnt("cnt_frozen");
        do_reset();
    endtask

    task automatic fetch_phase(input int fw);
        for (int i = 0; i < fw; i++) begin
            cyc(rnd6(), 1'b0, S_FETCH, C_RD, -1);
        end
        cyc(rnd6(), 1'b1, S_FETCH, C_RD | C_IRW | C_PCW, -1);
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        fetch_phase(fw);
        cyc(op, rnd1(), S_DECODE, 12'h000, -1);
        if (!supported(op)) begin
            hold_fault();
            return;
        end
        cyc(rnd6(), rnd1(), S_EXEC, exec_ctl(op), exec_alu(op));
        if (op == OP_LW || op == OP_SW) begin
            for (int i = 0; i < mw; i++) begin
                cyc(rnd6(), 1'b0, S_MEM, (op == OP_LW) ? C_RD : C_WR, -1);
            end
            cyc(rnd6(), 1'b1, S_MEM, (op == OP_LW) ? C_RD : C_WR, -1);
        end
        if (has_wb(op)) begin
            cyc(rnd6(), rnd1(), S_WB, wb_ctl(op), -1);
        end
        model_cnt++;
        check_cnt("cnt");
    endtask

    // Fifteen consecutive not-ready cycles in FETCH (in_mem=0) or in an LW's MEM.
    task automatic run_timeout(input logic in_mem);
        if (in_mem) begin
            fetch_phase(0);
            cyc(OP_LW, rnd1(), S_DECODE, 12'h000, -1);
            cyc(rnd6(), rnd1(), S_EXEC, C_IMM, 0);
        end
        for (int i = 0; i < 15; i++) begin
            cyc(rnd6(), 1'b0, in_mem ? S_MEM : S_FETCH, C_RD, -1);
        end
        hold_fault();
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl [9];
        tbl = '{OP_R, OP_ADDI, OP_ADDIU, OP_ANDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
        return tbl[$urandom_range(0, 8)];
    endfunction

    function automatic int pick_wait();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : 0;
    endfunction

    initial begin
        logic [5:0] uop;
        total         = 0;
        bad           = 0;
        model_cnt     = 0;
        nrst          = 1'b0;
        ifa.opcode    = 6'd0;
        ifa.mem_ready = 1'b0;
        ifb.opcode    = 6'd0;
        ifb.mem_ready = 1'b0;

        do_reset();

        // Directed instruction mix
        run_instr(OP_ADDI, 0, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_SW, 2, 1);
        run_instr(OP_R, 0, 0);
        run_instr(OP_ANDI, 1, 0);
        run_instr(OP_ADDIU, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_BNE, 0, 0);
        run_instr(OP_J, 0, 0);

        // Ready arriving on the last allowed cycle is a success
        run_instr(OP_ADDI, 14, 0);
        run_instr(OP_LW, 0, 14);
        run_instr(OP_SW, 14, 14);

        // Timeouts and unsupported opcode
        run_timeout(1'b0);
        run_instr(OP_J, 0, 0);
        run_timeout(1'b1);
        run_instr(6'b111111, 0, 0);
        run_instr(OP_R, 0, 0);

        // Reset while an ADDI sits in EXEC
        run_instr(OP_J, 0, 0);
        fetch_phase(0);
        cyc(OP_ADDI, 1'b1, S_DECODE, 12'h000, -1);
        do_reset();
        run_instr(OP_ADDI, 0, 0);

        // 4-bit counter wrap: 17 jumps from zero end at 1
        do_reset();
        for (int i = 0; i < 17; i++) begin
            run_instr(OP_J, 0, 0);
        end
        check("wrap_final_b", 32'(ifb.instr_count), 32'h1);

        // Randomized traffic
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 24))
                0: begin
                    uop = rnd6();
                    while (supported(uop)) uop = rnd6();
                    run_instr(uop, pick_wait(), 0);
                end
                1: run_timeout(rnd1());
                default: run_instr(pick_op(), pick_wait(), pick_wait());
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter ALUOP_W, default 4, width of alu_op bus (legal range 4..8; upper bits beyond 4 SHALL be zero).
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum wait cycles for mem_ready before fault (legal range 1..255).
REQ-003 Parameter CNT_W, default 16, width of retired-instruction counter.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 nrst  input  1  reset, synchronous, active-low.
REQ-006 opcode  input  6  instruction opcode field from the instruction register.
REQ-007 mem_ready  input  1  memory completion for the current read/write request.
REQ-008 read_mem  output  1  memory read request (instruction fetch or LW).
REQ-009 write_mem  output  1  memory write request (SW).
REQ-010 ir_write  output  1  instruction register load strobe.
REQ-011 pc_write  output  1  unconditional PC load.
REQ-012 pc_write_cond  output  1  PC load qualified by ALU zero flag (branch).
REQ-013 branch_ne  output  1  1 = load PC when zero flag clear (BNE); 0 = load when set (BEQ).
REQ-014 mux_pc_src  output  2  00 PC+4, 01 branch target, 10 jump target.
REQ-015 write_reg  output  1  register file write enable.
REQ-016 mux_write_rt_rd  output  1  0 = rt, 1 = rd destination.
REQ-017 mux_alu_src_reg_imm  output  1  0 = register, 1 = immediate operand B.
REQ-018 mux_reg_src_alu_mem  output  1  1 = ALU result, 0 = memory data to register file.
REQ-019 alu_op  output  ALUOP_W  ALU operation class: 0000 add, 0001 sub/beq, 0010 R-type funct, 0011 and, 0100 sub/bne.
REQ-020 state  output  3  current FSM state code.
REQ-021 fault  output  1  sticky fault indication.
REQ-022 instr_count  output  CNT_W  retired-instruction count.

Function
REQ-023 FSM states: FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, FAULT=111; other codes SHALL transition to FAULT.
REQ-024 FETCH: read_mem=1; when mem_ready=1, assert ir_write=1, pc_write=1 and mux_pc_src=00 in that cycle, then go to DECODE.
REQ-025 DECODE: latch opcode into an internal register; supported opcodes (000000 R, 001000 ADDI, 001001 ADDIU, 001100 ANDI, 100011 LW, 101011 SW, 000100 BEQ, 000101 BNE, 000010 J) go to EXEC; any other opcode goes to FAULT.
REQ-026 EXEC, and every state after DECODE: decoding SHALL use only the latched opcode; input opcode changes after DECODE SHALL have no effect.
REQ-027 EXEC actions: R-type alu_op=0010 mux_alu_src=0, then WB; ADDI/ADDIU alu_op=0000 mux_alu_src=1, then WB; ANDI alu_op=0011 mux_alu_src=1, then WB; LW/SW alu_op=0000 mux_alu_src=1, then MEM.
REQ-028 EXEC for BEQ/BNE: pc_write_cond=1, mux_pc_src=01, alu_op=0001 (BEQ) or 0100 (BNE), branch_ne=0/1 respectively, then FETCH.
REQ-029 EXEC for J: pc_write=1, mux_pc_src=10, then FETCH.
REQ-030 MEM: LW asserts read_mem, SW asserts write_mem, held until mem_ready=1; on ready, LW goes to WB and SW goes to FETCH.
REQ-031 WB: write_reg=1 for one cycle; mux_write_rt_rd=1 for R-type, 0 otherwise; mux_reg_src_alu_mem=0 for LW, 1 otherwise; then FETCH.
REQ-032 All strobes not listed for a state SHALL be 0; mux selects not listed SHALL be 0.
REQ-033 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0 in those states; reaching MEM_TIMEOUT with mem_ready=0 SHALL go to FAULT next cycle.
REQ-034 mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT SHALL count as success, not fault.
REQ-035 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-036 instr_count SHALL increment by 1 on each transition into FETCH from EXEC, MEM or WB, wrapping from all-ones to 0.
REQ-037 FAULT: fault=1, all strobes 0, state held until reset; instr_count frozen.
REQ-038 Latency: R/ADDI/ADDIU/ANDI 4 cycles, LW 5, SW 4, BEQ/BNE/J 3, each with zero memory wait.

Reset
REQ-039 When nrst=0 at a clock edge: state=FETCH, fault=0, instr_count=0, wait counter=0, latched opcode=000000.
REQ-040 While nrst=0, all strobe outputs SHALL be 0 combinationally, alu_op=0010 and all mux selects 0; reset mid-instruction SHALL abort it without counting.

Verification
REQ-041 Reset, then ADDI with mem_ready=1 always -> states 000,001,010,100,000; write_reg=1 only in WB; instr_count=1.
REQ-042 LW with 3 cycles of mem_ready=0 in MEM -> read_mem held 4 cycles; WB has mux_reg_src_alu_mem=0; instr_count increments once.
REQ-043 Fetch with mem_ready=0 for 15 cycles (MEM_TIMEOUT=15) -> fault=1, state=111; mem_ready=1 on 15th cycle -> no fault.
REQ-044 Opcode 111111 at DECODE -> FAULT; only nrst=0 clears it, then state=000, instr_count=0.
REQ-045 BNE then J -> EXEC shows pc_write_cond=1, branch_ne=1, mux_pc_src=01; then pc_write=1, mux_pc_src=10; opcode toggled during EXEC ignored.
REQ-046 CNT_W=4, 17 back-to-back J instructions -> instr_count wraps 1111 to 0000, ending at 0001.
